// File: rtl/maze_pkg.sv
// Shared definitions for the maze solver and its cell store.
package maze_pkg;

    localparam int MAZE_WIDTH_DEF = 6;
    localparam int MAZE_DIM_DEF   = 64;
    localparam int CNT_WIDTH_DEF  = 13;

    // Cell codes held in the grid; 2'd3 is reserved and never written.
    localparam logic [1:0] CELL_FREE    = 2'd0;
    localparam logic [1:0] CELL_WALL    = 2'd1;
    localparam logic [1:0] CELL_VISITED = 2'd2;

    // Solver heading encoding, kept here so solver and memory agree.
    localparam logic [1:0] UP    = 2'd0;
    localparam logic [1:0] LEFT  = 2'd1;
    localparam logic [1:0] DOWN  = 2'd2;
    localparam logic [1:0] RIGHT = 2'd3;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOAD,
        ST_SERVE,
        ST_DUMP
    } mem_state_e;

endpackage

// File: rtl/maze_cell_ram.sv
// Single-port cell array, one 2-bit code per maze cell.
// The read port is combinational and every consumer captures it in a register
// at the same edge that a write lands, so reads always see the pre-write value.
module maze_cell_ram #(
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [1:0]    wdata_i,
    output logic [1:0]    cell_o
);

    logic [1:0] mem_q [0:DEPTH-1];

    assign cell_o = mem_q[addr_i];

    // Synchronous write; contents are initialised by the controller's clear sweep.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/maze_memory.sv
// Cell store for the wall-follower solver: clear sweep after reset, streamed
// load of walls, 1-cycle registered solver reads/marks, streamed dump.
//
// state    | meaning
// ---------+------------------------------------------------------------
// CLEAR    | writing FREE to every cell, one per cycle, inputs ignored
// IDLE     | one bubble cycle; launches a requested load or dump
// LOAD     | accepting wall bits, one cell per accepted beat
// SERVE    | answering solver reads and mark-visited writes
// DUMP     | streaming every cell code out with valid/ready
module maze_memory
    import maze_pkg::*;
#(
    parameter int MAZE_WIDTH = MAZE_WIDTH_DEF,
    parameter int MAZE_DIM   = MAZE_DIM_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MAZE_WIDTH-1:0] row,
    input  logic [MAZE_WIDTH-1:0] col,
    input  logic                  maze_oe,
    input  logic                  maze_we,
    output logic                  maze_in,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic                  load_data,
    output logic                  load_ready,
    input  logic                  dump_start,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [1:0]            dump_data,
    output logic                  dump_last,
    output logic                  mem_ready,
    output logic [CNT_WIDTH-1:0]  visited_count
);

    localparam int AW    = 2 * MAZE_WIDTH;
    localparam int DEPTH = MAZE_DIM * MAZE_DIM;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEPTH - 1);

    mem_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic [CNT_WIDTH-1:0] vc_q, vc_d;
    logic                 maze_in_q, maze_in_d;
    logic [1:0]           dump_data_q, dump_data_d;
    logic                 pend_load_q, pend_load_d;
    logic                 pend_dump_q, pend_dump_d;

    logic [AW-1:0]        ram_addr;
    logic                 ram_we;
    logic [1:0]           ram_wdata;
    logic [1:0]           ram_cell;

    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

    maze_cell_ram #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .wdata_i (ram_wdata),
        .cell_o  (ram_cell)
    );

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            vc_q        <= '0;
            maze_in_q   <= 1'b0;
            dump_data_q <= CELL_FREE;
            pend_load_q <= 1'b0;
            pend_dump_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vc_q        <= vc_d;
            maze_in_q   <= maze_in_d;
            dump_data_q <= dump_data_d;
            pend_load_q <= pend_load_d;
            pend_dump_q <= pend_dump_d;
        end
    end

    // Next-state logic and RAM port mux for the clear/load/serve/dump sources.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vc_d        = vc_q;
        maze_in_d   = maze_in_q;
        dump_data_d = dump_data_q;
        pend_load_d = pend_load_q;
        pend_dump_d = pend_dump_q;
        ram_addr    = cnt_q[AW-1:0];
        ram_we      = 1'b0;
        ram_wdata   = CELL_FREE;

        case (state_q)
            ST_CLEAR: begin
                ram_we = 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_IDLE: begin
                // Address 0 is presented so a dump starts with cell 0 prefetched.
                cnt_d       = '0;
                ram_addr    = '0;
                pend_load_d = 1'b0;
                pend_dump_d = 1'b0;
                if (load_start || pend_load_q) begin
                    state_d = ST_LOAD;
                end else if (dump_start || pend_dump_q) begin
                    state_d     = ST_DUMP;
                    dump_data_d = ram_cell;
                end else begin
                    state_d = ST_SERVE;
                end
            end

            ST_LOAD: begin
                ram_wdata = load_data ? CELL_WALL : CELL_FREE;
                if (load_valid) begin
                    ram_we = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        vc_d    = '0;
                        state_d = ST_SERVE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            ST_SERVE: begin
                ram_addr  = {row, col};
                ram_wdata = CELL_VISITED;
                if (maze_oe) begin
                    maze_in_d = (ram_cell == CELL_WALL);
                end
                // Only FREE cells become VISITED: walls stay, repeats are not recounted.
                if (maze_we && (ram_cell == CELL_FREE)) begin
                    ram_we = 1'b1;
                    vc_d   = vc_q + CNT_WIDTH'(1);
                end
                if (load_start) begin
                    pend_load_d = 1'b1;
                    state_d     = ST_IDLE;
                end else if (dump_start) begin
                    pend_dump_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            ST_DUMP: begin
                // Prefetch the cell that will be current after this edge.
                if (dump_ready) begin
                    ram_addr = cnt_inc[AW-1:0];
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SERVE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                dump_data_d = ram_cell;
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign mem_ready     = (state_q == ST_SERVE);
    assign load_ready    = (state_q == ST_LOAD);
    assign dump_valid    = (state_q == ST_DUMP);
    assign dump_last     = (state_q == ST_DUMP) && (cnt_q == LAST);
    assign maze_in       = maze_in_q;
    assign dump_data     = dump_data_q;
    assign visited_count = vc_q;

endmodule

// File: tb/tb_maze_memory.sv
module tb_maze_memory;
    import maze_pkg::*;

    localparam int N = 4096;

    logic        clk;
    logic        rst_n;
    logic [5:0]  row, col;
    logic        maze_oe, maze_we, maze_in;
    logic        load_start, load_valid, load_data, load_ready;
    logic        dump_start, dump_valid, dump_ready, dump_last;
    logic [1:0]  dump_data;
    logic        mem_ready;
    logic [12:0] visited_count;

    maze_memory #(.MAZE_WIDTH(6), .MAZE_DIM(64), .CNT_WIDTH(13)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .row           (row),
        .col           (col),
        .maze_oe       (maze_oe),
        .maze_we       (maze_we),
        .maze_in       (maze_in),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_ready    (load_ready),
        .dump_start    (dump_start),
        .dump_valid    (dump_valid),
        .dump_ready    (dump_ready),
        .dump_data     (dump_data),
        .dump_last     (dump_last),
        .mem_ready     (mem_ready),
        .visited_count (visited_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain array of cell codes plus visit count and last read.
    int   model [N];
    int   cap   [N];
    int   m_vc;
    logic m_in;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int r;
        int c;
        bit oe;
        bit we;
        bit exp_in;
        int exp_vc;
    } vec_t;
    vec_t tbl [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " mem_ready"}, 32'(mem_ready), 0);
        check({tag, " load_ready"}, 32'(load_ready), 0);
        check({tag, " dump_valid"}, 32'(dump_valid), 0);
        check({tag, " dump_last"}, 32'(dump_last), 0);
        check({tag, " dump_data"}, 32'(dump_data), 0);
        check({tag, " maze_in"}, 32'(maze_in), 0);
        check({tag, " visited_count"}, 32'(visited_count), 0);
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) model[i] = 0;
        m_vc = 0;
        m_in = 1'b0;
    endtask

    task automatic wait_serve(input int exp_cycles);
        int n;
        n = 0;
        while (!mem_ready && n < 6000) begin
            tick();
            n++;
        end
        check("mem_ready reached", 32'(mem_ready), 1);
        if (exp_cycles >= 0) check("clear sweep cycles", n, exp_cycles);
    endtask

    function automatic bit border_bit(input int i);
        int r, c;
        r = i / 64;
        c = i % 64;
        return (r == 0) || (r == 63) || (c == 0) || (c == 63);
    endfunction

    // mode 0: border walls; mode 1: random walls. abort_at >= 0 resets mid-load.
    task automatic do_load(input int mode, input int gap_min, input int gap_max, input int abort_at);
        int n;
        bit b;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        n = 0;
        while (!load_ready && n < 20) begin
            tick();
            n++;
        end
        check("load_ready reached", 32'(load_ready), 1);
        for (int i = 0; i < N; i++) begin
            if (i == abort_at) begin
                rst_n      = 1'b0;
                load_valid = 1'b0;
                #1;
                check_reset_outputs("abort");
                model_clear();
                tick();
                rst_n = 1'b1;
                wait_serve(4097);
                return;
            end
            b          = (mode == 0) ? border_bit(i) : ($urandom_range(3, 0) == 0);
            load_valid = 1'b1;
            load_data  = b;
            model[i]   = b ? 1 : 0;
            tick();
            load_valid = 1'b0;
            repeat ($urandom_range(gap_max, gap_min)) tick();
        end
        m_vc = 0;
        wait_serve(-1);
        check("visited after load", 32'(visited_count), 32'(m_vc));
    endtask

    // mode 0: always ready; 1: ready every other cycle; 2: random ready.
    task automatic do_dump(input int mode);
        int  beat, n, errs_d, errs_l;
        bit  rdy;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        beat = 0; n = 0; errs_d = 0; errs_l = 0;
        while (beat < N && n < 4 * N + 20) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = n[0];
                default: rdy = ($urandom_range(3, 0) != 0);
            endcase
            dump_ready = rdy;
            if (dump_valid && rdy) begin
                cap[beat] = int'(dump_data);
                if (int'(dump_data) != model[beat]) errs_d++;
                if (dump_last !== (beat == N - 1)) errs_l++;
                beat++;
            end else if (dump_valid && dump_last && beat != N - 1) begin
                errs_l++;
            end
            tick();
            n++;
        end
        dump_ready = 1'b0;
        check("dump beat count", beat, N);
        check("dump data errors", errs_d, 0);
        check("dump last errors", errs_l, 0);
        check("serve after dump", 32'(mem_ready), 1);
        check("dump_valid after dump", 32'(dump_valid), 0);
        check("visited after dump", 32'(visited_count), 32'(m_vc));
        check("maze_in held over dump", 32'(maze_in), 32'(m_in));
    endtask

    task automatic random_serve(input int cycles);
        int r, c, a;
        bit oe, we;
        for (int k = 0; k < cycles; k++) begin
            if ($urandom_range(1, 0) == 1) begin
                r = $urandom_range(3, 0);
                c = $urandom_range(3, 0);
            end else begin
                r = $urandom_range(63, 0);
                c = $urandom_range(63, 0);
            end
            oe = $urandom_range(1, 0) == 1;
            we = $urandom_range(2, 0) == 0;
            a  = r * 64 + c;
            if (oe) m_in = (model[a] == 1);
            if (we && model[a] == 0) begin
                model[a] = 2;
                m_vc++;
            end
            row = 6'(r); col = 6'(c); maze_oe = oe; maze_we = we;
            tick();
            check("rand maze_in", 32'(maze_in), 32'(m_in));
            check("rand visited_count", 32'(visited_count), 32'(m_vc));
        end
        maze_oe = 1'b0;
        maze_we = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{0,  5,  1, 0, 1, 0};
        tbl[1]  = '{5,  5,  1, 0, 0, 0};
        tbl[2]  = '{5,  5,  0, 1, 0, 1};
        tbl[3]  = '{5,  5,  0, 1, 0, 1};
        tbl[4]  = '{0,  5,  0, 1, 0, 1};
        tbl[5]  = '{0,  5,  1, 0, 1, 1};
        tbl[6]  = '{7,  7,  1, 1, 0, 2};
        tbl[7]  = '{7,  7,  1, 0, 0, 2};
        tbl[8]  = '{0,  0,  1, 0, 1, 2};
        tbl[9]  = '{63, 63, 0, 1, 1, 2};
        tbl[10] = '{62, 62, 1, 1, 0, 3};
        tbl[11] = '{62, 62, 0, 1, 0, 3};

        rst_n = 1'b0;
        row = '0; col = '0; maze_oe = 1'b0; maze_we = 1'b0;
        load_start = 1'b0; load_valid = 1'b0; load_data = 1'b0;
        dump_start = 1'b0; dump_ready = 1'b0;
        model_clear();
        #12;
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        wait_serve(4097);

        do_dump(0);

        do_load(0, 3, 3, -1);

        for (int i = 0; i < 12; i++) begin
            int a;
            a = tbl[i].r * 64 + tbl[i].c;
            if (tbl[i].we && model[a] == 0) begin
                model[a] = 2;
                m_vc++;
            end
            row = 6'(tbl[i].r); col = 6'(tbl[i].c);
            maze_oe = tbl[i].oe; maze_we = tbl[i].we;
            tick();
            maze_oe = 1'b0; maze_we = 1'b0;
            check($sformatf("tbl[%0d] maze_in", i), 32'(maze_in), 32'(tbl[i].exp_in));
            check($sformatf("tbl[%0d] visited_count", i), 32'(visited_count), 32'(tbl[i].exp_vc));
        end
        m_in = tbl[11].exp_in;

        do_dump(1);
        check("cell 325 visited", cap[325], 2);
        check("cell 5 wall kept", cap[5], 1);
        check("cell (7,7) visited", cap[7 * 64 + 7], 2);
        check("cell (63,63) wall kept", cap[63 * 64 + 63], 1);

        random_serve(300);
        do_dump(2);

        do_load(1, 0, 1, -1);
        random_serve(300);
        do_dump(0);

        do_load(1, 0, 0, 100);
        do_dump(0);
        check("visited after abort", 32'(visited_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
